// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int WORD      = 32;
  localparam int INSTR_LEN = 32;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Next-PC selection (branch > stall > sequential) with alignment/range check.
module pc_next_sel
  import fetch_unit_pkg::*;
#(
  parameter int IMEM_SIZE = 1024
) (
  input  logic [WORD-1:0] pc,
  input  logic            branch_taken,
  input  logic [WORD-1:0] branch_target,
  input  logic            stall,
  output logic [WORD-1:0] next_pc,
  output logic            next_fault
);

  localparam longint unsigned LIMIT = longint'(IMEM_SIZE) * 4;

  logic [WORD:0] seq_sum;
  logic          wrap;

  // Carry out of pc+4 would alias to a low address; treat it as a fault.
  assign seq_sum = {1'b0, pc} + (WORD+1)'(4);

  always_comb begin
    next_pc = seq_sum[WORD-1:0];
    wrap    = seq_sum[WORD];
    if (branch_taken) begin
      next_pc = branch_target;
      wrap    = 1'b0;
    end else if (stall) begin
      next_pc = pc;
      wrap    = 1'b0;
    end
  end

  assign next_fault = wrap || (next_pc[1:0] != 2'b00) || (64'(next_pc) >= LIMIT);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, stall/branch handling, sticky fault.
// Optional macro BRANCH_SQUASH_EN turns the branch delay slot into a bubble.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC  = '0,
  parameter int              IMEM_SIZE = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [WORD-1:0]      branch_target,
  output logic [WORD-1:0]      imem_addr,
  input  logic [INSTR_LEN-1:0] imem_instr,
  output logic [WORD-1:0]      if_pc,
  output logic [INSTR_LEN-1:0] if_instr,
  output logic                 if_valid,
  output logic                 fetch_fault
);

  fetch_state_t    state, state_nxt;
  logic [WORD-1:0] pc, pc_nxt, pc_q, pc_q_nxt;
  logic            valid_q, valid_nxt;
  logic [WORD-1:0] next_pc;
  logic            next_fault;
  logic            run;
  logic            branch_valid;

  assign run = (state == RUN);

`ifdef BRANCH_SQUASH_EN
  assign branch_valid = 1'b0;
`else
  assign branch_valid = 1'b1;
`endif

  // Outside RUN the request inputs are ignored, so FILL sees a plain pc+4.
  pc_next_sel #(.IMEM_SIZE(IMEM_SIZE)) u_sel (
    .pc            (pc),
    .branch_taken  (branch_taken & run),
    .branch_target (branch_target),
    .stall         (stall & run),
    .next_pc       (next_pc),
    .next_fault    (next_fault)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pc_q_nxt  = pc_q;
    valid_nxt = valid_q;
    case (state)
      FILL, RUN: begin
        if (next_fault) begin
          state_nxt = FAULT;
          valid_nxt = 1'b0;
        end else if (run && branch_taken) begin
          pc_nxt    = next_pc;
          pc_q_nxt  = pc;
          valid_nxt = branch_valid;
        end else if (!(run && stall)) begin
          state_nxt = RUN;
          pc_nxt    = next_pc;
          pc_q_nxt  = pc;
          valid_nxt = 1'b1;
        end
      end
      FAULT:   valid_nxt = 1'b0;
      default: begin
        state_nxt = FAULT;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      pc      <= RESET_PC;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pc_q    <= pc_q_nxt;
      valid_q <= valid_nxt;
    end
  end

  assign imem_addr   = pc;
  assign if_pc       = pc_q;
  assign if_instr    = imem_instr;
  assign if_valid    = valid_q && run;
  assign fetch_fault = (state == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered instruction memory (word k holds k).
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 stall;
  logic                 branch_taken;
  logic [WORD-1:0]      branch_target;
  logic [WORD-1:0]      imem_addr;
  logic [INSTR_LEN-1:0] imem_instr;
  logic [WORD-1:0]      if_pc;
  logic [INSTR_LEN-1:0] if_instr;
  logic                 if_valid;
  logic                 fetch_fault;

  int n_cmp = 0;
  int n_err = 0;

`ifdef BRANCH_SQUASH_EN
  localparam logic BV = 1'b0;
`else
  localparam logic BV = 1'b1;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'd0), .IMEM_SIZE(1024)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_valid      (if_valid),
    .fetch_fault   (fetch_fault)
  );

  // Memory holds its output while the pipe is stalled, keeping if_instr stable.
  always @(posedge clk)
    if (!stall || branch_taken) imem_instr <= imem_addr >> 2;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    tick(); tick();
    n_cmp++;
    if ({if_valid, fetch_fault, if_pc, imem_addr} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL reset: got v=%b f=%b pc=%h addr=%h want 0/0/0/0",
               if_valid, fetch_fault, if_pc, imem_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 32'(4 * k), 32'(k)}) begin
        n_err++;
        $display("FAIL seq%0d: got v=%b pc=%h instr=%h want 1/%h/%h",
                 k, if_valid, if_pc, if_instr, 4 * k, k);
      end
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'd12, 32'd3, 32'd16}) begin
        n_err++;
        $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h addr=%h want 1/c/3/10",
                 k, if_valid, if_pc, if_instr, imem_addr);
      end
    end
    stall = 1'b0;
    tick();
    n_cmp++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd16, 32'd4}) begin
      n_err++;
      $display("FAIL stall_resume: got v=%b pc=%h instr=%h want 1/10/4",
               if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_branch;
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
    n_cmp++;
    if ({if_valid, if_pc, if_instr, imem_addr} !== {BV, 32'd20, 32'd5, 32'h40}) begin
      n_err++;
      $display("FAIL branch_slot: got v=%b pc=%h instr=%h addr=%h want %b/14/5/40",
               if_valid, if_pc, if_instr, imem_addr, BV);
    end
    tick();
    n_cmp++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h40, 32'd16}) begin
      n_err++;
      $display("FAIL branch_target: got v=%b pc=%h instr=%h want 1/40/10",
               if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_branch_stall;
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h20;
    tick();
    stall = 1'b0; branch_taken = 1'b0;
    n_cmp++;
    if ({if_valid, if_pc, imem_addr} !== {BV, 32'h44, 32'h20}) begin
      n_err++;
      $display("FAIL brstall_slot: got v=%b pc=%h addr=%h want %b/44/20",
               if_valid, if_pc, imem_addr, BV);
    end
    tick();
    n_cmp++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h20, 32'd8}) begin
      n_err++;
      $display("FAIL brstall_target: got v=%b pc=%h instr=%h want 1/20/8",
               if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 4; k++) tick();
    n_cmp++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h30, 32'd12}) begin
      n_err++;
      $display("FAIL mid_pre: got v=%b pc=%h instr=%h want 1/30/c", if_valid, if_pc, if_instr);
    end
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if_valid, fetch_fault, if_pc, imem_addr} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL mid_async: got v=%b f=%b pc=%h addr=%h want 0/0/0/0",
               if_valid, fetch_fault, if_pc, imem_addr);
    end
    tick();
    stall = 1'b0; branch_taken = 1'b0; rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 32'(4 * k), 32'(k)}) begin
        n_err++;
        $display("FAIL mid_restart%0d: got v=%b pc=%h instr=%h want 1/%h/%h",
                 k, if_valid, if_pc, if_instr, 4 * k, k);
      end
    end
  endtask

  task automatic test_fault_misaligned;
    branch_taken = 1'b1; branch_target = 32'h42;
    tick();
    branch_taken = 1'b0;
    n_cmp++;
    if ({fetch_fault, if_valid, imem_addr, if_pc} !== {1'b1, 1'b0, 32'd8, 32'd4}) begin
      n_err++;
      $display("FAIL misalign: got f=%b v=%b addr=%h pc=%h want 1/0/8/4",
               fetch_fault, if_valid, imem_addr, if_pc);
    end
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    stall = 1'b0; branch_taken = 1'b0;
    tick();
    n_cmp++;
    if ({fetch_fault, if_valid, imem_addr, if_pc} !== {1'b1, 1'b0, 32'd8, 32'd4}) begin
      n_err++;
      $display("FAIL fault_frozen: got f=%b v=%b addr=%h pc=%h want 1/0/8/4",
               fetch_fault, if_valid, imem_addr, if_pc);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({fetch_fault, if_valid, if_pc, if_instr} !== {1'b0, 1'b1, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL fault_recover: got f=%b v=%b pc=%h instr=%h want 0/1/0/0",
               fetch_fault, if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_fault_range;
    branch_taken = 1'b1; branch_target = 32'hFFC;
    tick();
    branch_taken = 1'b0;
    n_cmp++;
    if ({fetch_fault, if_valid, if_pc, imem_addr} !== {1'b0, BV, 32'd4, 32'hFFC}) begin
      n_err++;
      $display("FAIL range_last: got f=%b v=%b pc=%h addr=%h want 0/%b/4/ffc",
               fetch_fault, if_valid, if_pc, imem_addr, BV);
    end
    tick();
    n_cmp++;
    if ({fetch_fault, if_valid, imem_addr} !== {1'b1, 1'b0, 32'hFFC}) begin
      n_err++;
      $display("FAIL range_fault: got f=%b v=%b addr=%h want 1/0/ffc",
               fetch_fault, if_valid, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_stall();
    test_reset_mid();
    test_fault_misaligned();
    test_fault_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
